// File: rtl/key_search_controller.sv
// ---------------------------------------------------------------------------
// key_search_controller
//
// Top-level sequencer for the RC4 brute-force key search. For every candidate
// key it runs the S-memory init machine, then the swap (KSA) machine, then the
// decryption machine. It owns the shared S-memory port select and the
// candidate-key counter. A passing decryption parks the FSM in FOUND with the
// key held. A failing one advances to the next key, and the search reports
// exhaustion once the key counter reaches KEY_LIMIT.
//
// Start/done handshake (same for all three sub-machines): *_start is a
// one-cycle pulse issued from the matching *_GO state. The sub-machine answers
// with a one-cycle *_done pulse at least one cycle later. A done pulse is only
// sampled in its own *_WAIT state and is ignored everywhere else. dec_pass is
// meaningful only in the cycle dec_done is high.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   go                    start/restart pulse (honoured only when not busy)
//   init_start/init_done  S-memory init machine handshake
//   swap_start/swap_done  swap (KSA) machine handshake
//   dec_start/dec_done    decryption machine handshake, dec_pass = result
//   mem_sel               S-memory owner: 0 init, 1 swap, 2 decrypt, 3 none
//   secret_key            current candidate key
//   busy/found/not_found/error  search status
//   state_dbg             current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module key_search_controller #(
    parameter int                   KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_LIMIT = 24'h400000,
    parameter int                   TIMEOUT   = 4096
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 go,
    output logic                 init_start,
    input  logic                 init_done,
    output logic                 swap_start,
    input  logic                 swap_done,
    output logic                 dec_start,
    input  logic                 dec_done,
    input  logic                 dec_pass,
    output logic [1:0]           mem_sel,
    output logic [KEY_WIDTH-1:0] secret_key,
    output logic                 busy,
    output logic                 found,
    output logic                 not_found,
    output logic                 error,
    output logic [3:0]           state_dbg
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    // The count reaches TIMEOUT on the edge that leaves a WAIT state, so the
    // error decision is made while the register still holds TIMEOUT-1.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        INIT_GO   = 4'd1,
        INIT_WAIT = 4'd2,
        SWAP_GO   = 4'd3,
        SWAP_WAIT = 4'd4,
        DEC_GO    = 4'd5,
        DEC_WAIT  = 4'd6,
        NEXT_KEY  = 4'd7,
        FOUND     = 4'd8,
        EXHAUSTED = 4'd9,
        ERROR     = 4'd10
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [KEY_WIDTH-1:0]   key_nx;
    logic [KEY_WIDTH-1:0]   key_inc;
    logic [WD_W-1:0]        wdog;
    logic [WD_W-1:0]        wdog_nx;
    logic                   wd_expired;

    assign key_inc    = secret_key + KEY_WIDTH'(1);
    assign wd_expired = (wdog == WD_LAST);
    assign state_dbg  = state;

    // Next-state logic. The watchdog is zero in every non-WAIT state, so it
    // is automatically cleared on entry to each WAIT state. A done pulse is
    // tested before the timeout so it wins on the final count.
    always_comb begin
        state_nx = state;
        key_nx   = secret_key;
        wdog_nx  = '0;
        case (state)
            IDLE, FOUND, EXHAUSTED, ERROR: begin
                if (go) begin
                    state_nx = INIT_GO;
                    key_nx   = '0;
                end
            end
            INIT_GO:  state_nx = INIT_WAIT;
            INIT_WAIT: begin
                if (init_done)       state_nx = SWAP_GO;
                else if (wd_expired) state_nx = ERROR;
                else                 wdog_nx  = wdog + WD_W'(1);
            end
            SWAP_GO:  state_nx = SWAP_WAIT;
            SWAP_WAIT: begin
                if (swap_done)       state_nx = DEC_GO;
                else if (wd_expired) state_nx = ERROR;
                else                 wdog_nx  = wdog + WD_W'(1);
            end
            DEC_GO:   state_nx = DEC_WAIT;
            DEC_WAIT: begin
                if (dec_done)        state_nx = dec_pass ? FOUND : NEXT_KEY;
                else if (wd_expired) state_nx = ERROR;
                else                 wdog_nx  = wdog + WD_W'(1);
            end
            NEXT_KEY: begin
                key_nx   = key_inc;
                state_nx = (key_inc == KEY_LIMIT) ? EXHAUSTED : INIT_GO;
            end
            default:  state_nx = IDLE;
        endcase
    end

    // State, key, watchdog and all Moore outputs are registered together;
    // outputs are decoded from the next state so they line up with the state
    // they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            secret_key <= '0;
            wdog       <= '0;
            init_start <= 1'b0;
            swap_start <= 1'b0;
            dec_start  <= 1'b0;
            mem_sel    <= 2'd3;
            busy       <= 1'b0;
            found      <= 1'b0;
            not_found  <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_nx;
            secret_key <= key_nx;
            wdog       <= wdog_nx;
            init_start <= (state_nx == INIT_GO);
            swap_start <= (state_nx == SWAP_GO);
            dec_start  <= (state_nx == DEC_GO);
            if (state_nx == INIT_GO || state_nx == INIT_WAIT)
                mem_sel <= 2'd0;
            else if (state_nx == SWAP_GO || state_nx == SWAP_WAIT)
                mem_sel <= 2'd1;
            else if (state_nx == DEC_GO || state_nx == DEC_WAIT)
                mem_sel <= 2'd2;
            else
                mem_sel <= 2'd3;
            busy      <= !(state_nx == IDLE || state_nx == FOUND ||
                           state_nx == EXHAUSTED || state_nx == ERROR);
            found     <= (state_nx == FOUND);
            not_found <= (state_nx == EXHAUSTED);
            error     <= (state_nx == ERROR);
        end
    end

endmodule

// File: tb/tb_key_search_controller.sv
// ---------------------------------------------------------------------------
// tb_key_search_controller
//
// Self-checking bench for key_search_controller with KEY_LIMIT=4, TIMEOUT=16.
// The bench plays the three sub-machines, pushes the key it expects to see at
// each dec_start onto exp_q when it launches a search, and pops/compares when
// the controller issues dec_start. Inputs are driven and outputs sampled on
// the falling clock edge.
// ---------------------------------------------------------------------------
module tb_key_search_controller;

    localparam int          KW  = 24;
    localparam logic [KW-1:0] LIM = 24'd4;
    localparam int          TO  = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          go = 1'b0;
    logic          init_done = 1'b0;
    logic          swap_done = 1'b0;
    logic          dec_done = 1'b0;
    logic          dec_pass = 1'b0;
    logic          init_start, swap_start, dec_start;
    logic [1:0]    mem_sel;
    logic [KW-1:0] secret_key;
    logic          busy, found, not_found, error;
    logic [3:0]    state_dbg;

    key_search_controller #(
        .KEY_WIDTH (KW),
        .KEY_LIMIT (LIM),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .go         (go),
        .init_start (init_start),
        .init_done  (init_done),
        .swap_start (swap_start),
        .swap_done  (swap_done),
        .dec_start  (dec_start),
        .dec_done   (dec_done),
        .dec_pass   (dec_pass),
        .mem_sel    (mem_sel),
        .secret_key (secret_key),
        .busy       (busy),
        .found      (found),
        .not_found  (not_found),
        .error      (error),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [KW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int init_pulses = 0;

    always @(negedge clk) if (init_start === 1'b1) init_pulses++;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        cyc();
        go = 1'b0;
    endtask

    task automatic push_keys(input int last);
        for (int k = 0; k <= last; k++) exp_q.push_back(KW'(k));
    endtask

    task automatic wait_start(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if ((which == 0 && init_start === 1'b1) ||
                (which == 1 && swap_start === 1'b1) ||
                (which == 2 && dec_start === 1'b1)) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    // Plays one sub-machine: waits for its start, checks the pulse and the
    // memory select, then returns done after lat cycles.
    task automatic run_phase(input int which, input int lat, input bit pass);
        bit            ok;
        logic          cur;
        logic          nxt;
        logic [KW-1:0] exp_key;
        logic [1:0]    exp_sel;
        exp_sel = 2'(which);
        wait_start(which, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL start_timeout: phase %0d start not seen within 64 cycles", which);
            return;
        end
        n_cmp++;
        if (mem_sel !== exp_sel || busy !== 1'b1) begin
            n_err++;
            $display("FAIL go_state: mem_sel=%0d busy=%0b, expected mem_sel=%0d busy=1", mem_sel, busy, exp_sel);
        end
        if (which == 2) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL key_order: dec_start with key %0h but none expected", secret_key);
            end else begin
                exp_key = exp_q.pop_front();
                if (secret_key !== exp_key) begin
                    n_err++;
                    $display("FAIL key_order: secret_key=%0h expected %0h", secret_key, exp_key);
                end
            end
        end
        cyc();
        cur = (which == 0) ? init_start : (which == 1) ? swap_start : dec_start;
        n_cmp++;
        if (cur !== 1'b0 || mem_sel !== exp_sel) begin
            n_err++;
            $display("FAIL start_width: phase %0d start=%0b mem_sel=%0d, expected start=0 mem_sel=%0d", which, cur, mem_sel, exp_sel);
        end
        repeat (lat - 1) cyc();
        case (which)
            0:       init_done = 1'b1;
            1:       swap_done = 1'b1;
            default: begin dec_done = 1'b1; dec_pass = pass; end
        endcase
        cyc();
        init_done = 1'b0; swap_done = 1'b0; dec_done = 1'b0; dec_pass = 1'b0;
        if (which < 2) begin
            nxt = (which == 0) ? swap_start : dec_start;
            n_cmp++;
            if (nxt !== 1'b1 || mem_sel !== 2'(which + 1)) begin
                n_err++;
                $display("FAIL handoff: phase %0d next start=%0b mem_sel=%0d, expected 1 and %0d", which, nxt, mem_sel, which + 1);
            end
        end
    endtask

    // Serves a whole search; pass_key < 0 means every key fails.
    task automatic serve(input int pass_key, input int il, input int sl, input int dl);
        for (int k = 0; k < int'(LIM); k++) begin
            run_phase(0, il, 1'b0);
            run_phase(1, sl, 1'b0);
            run_phase(2, dl, k == pass_key);
            if (k == pass_key) begin
                n_cmp++;
                if (found !== 1'b1 || busy !== 1'b0 || mem_sel !== 2'd3 || secret_key !== KW'(k)) begin
                    n_err++;
                    $display("FAIL found_state: found=%0b busy=%0b mem_sel=%0d key=%0h, expected 1 0 3 %0h", found, busy, mem_sel, secret_key, k);
                end
                return;
            end
            n_cmp++;
            if (mem_sel !== 2'd3 || busy !== 1'b1 || found !== 1'b0 || secret_key !== KW'(k)) begin
                n_err++;
                $display("FAIL next_key: mem_sel=%0d busy=%0b found=%0b key=%0h, expected 3 1 0 %0h", mem_sel, busy, found, secret_key, k);
            end
            cyc();
            if (k == int'(LIM) - 1) begin
                n_cmp++;
                if (not_found !== 1'b1 || busy !== 1'b0 || mem_sel !== 2'd3 || secret_key !== LIM) begin
                    n_err++;
                    $display("FAIL exhausted: not_found=%0b busy=%0b mem_sel=%0d key=%0h, expected 1 0 3 %0h", not_found, busy, mem_sel, secret_key, LIM);
                end
                return;
            end
            n_cmp++;
            if (init_start !== 1'b1 || secret_key !== KW'(k + 1)) begin
                n_err++;
                $display("FAIL key_advance: init_start=%0b key=%0h, expected 1 %0h", init_start, secret_key, k + 1);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) cyc();
        n_cmp++;
        if (init_start !== 1'b0 || swap_start !== 1'b0 || dec_start !== 1'b0 || mem_sel !== 2'd3 ||
            secret_key !== '0 || busy !== 1'b0 || found !== 1'b0 || not_found !== 1'b0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: starts=%0b%0b%0b mem_sel=%0d key=%0h flags=%0b%0b%0b%0b", init_start, swap_start, dec_start, mem_sel, secret_key, busy, found, not_found, error);
        end
        reset_n = 1'b1;
        // Stray done in IDLE must not start anything.
        dec_done = 1'b1; dec_pass = 1'b1;
        cyc();
        dec_done = 1'b0; dec_pass = 1'b0;
        cyc();
        n_cmp++;
        if (busy !== 1'b0 || found !== 1'b0 || mem_sel !== 2'd3) begin
            n_err++;
            $display("FAIL idle_stray: busy=%0b found=%0b mem_sel=%0d, expected 0 0 3", busy, found, mem_sel);
        end
    endtask

    task automatic test_found_first();
        int p0;
        p0 = init_pulses;
        push_keys(0);
        pulse_go();
        n_cmp++;
        if (init_start !== 1'b1 || busy !== 1'b1 || mem_sel !== 2'd0 || secret_key !== '0) begin
            n_err++;
            $display("FAIL go_latency: init_start=%0b busy=%0b mem_sel=%0d key=%0h, expected 1 1 0 0", init_start, busy, mem_sel, secret_key);
        end
        serve(0, 3, 5, 2);
        n_cmp++;
        if (init_pulses - p0 !== 1) begin
            n_err++;
            $display("FAIL first_init_count: %0d init pulses, expected 1", init_pulses - p0);
        end
    endtask

    task automatic test_found_later();
        int p0;
        p0 = init_pulses;
        push_keys(2);
        pulse_go();
        serve(2, 2, 1, 3);
        n_cmp++;
        if (init_pulses - p0 !== 3) begin
            n_err++;
            $display("FAIL later_init_count: %0d init pulses, expected 3", init_pulses - p0);
        end
    endtask

    task automatic test_exhaustion();
        push_keys(int'(LIM) - 1);
        pulse_go();
        serve(-1, 1, 2, 1);
        cyc();
        n_cmp++;
        if (not_found !== 1'b1 || secret_key !== LIM) begin
            n_err++;
            $display("FAIL exhausted_hold: not_found=%0b key=%0h, expected 1 %0h", not_found, secret_key, LIM);
        end
        push_keys(0);
        pulse_go();
        n_cmp++;
        if (secret_key !== '0 || not_found !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL restart: key=%0h not_found=%0b busy=%0b, expected 0 0 1", secret_key, not_found, busy);
        end
        serve(0, 1, 1, 1);
    endtask

    task automatic test_watchdog();
        bit ok;
        pulse_go();
        cyc();                      // first INIT_WAIT cycle
        repeat (TO - 1) cyc();
        n_cmp++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL wd_early: error=%0b busy=%0b at cycle %0d, expected 0 1", error, busy, TO - 1);
        end
        cyc();
        n_cmp++;
        if (error !== 1'b1 || busy !== 1'b0 || mem_sel !== 2'd3) begin
            n_err++;
            $display("FAIL wd_error: error=%0b busy=%0b mem_sel=%0d, expected 1 0 3", error, busy, mem_sel);
        end
        // done on the final watchdog cycle wins
        push_keys(0);
        pulse_go();
        run_phase(0, 1, 1'b0);      // leaves us observing SWAP_GO
        cyc();                      // first SWAP_WAIT cycle
        repeat (TO - 1) cyc();
        swap_done = 1'b1;
        cyc();
        swap_done = 1'b0;
        n_cmp++;
        if (error !== 1'b0 || dec_start !== 1'b1 || mem_sel !== 2'd2) begin
            n_err++;
            $display("FAIL wd_done_wins: error=%0b dec_start=%0b mem_sel=%0d, expected 0 1 2", error, dec_start, mem_sel);
        end
        wait_start(2, ok);
        run_phase(2, 2, 1'b1);
        n_cmp++;
        if (found !== 1'b1 || error !== 1'b0) begin
            n_err++;
            $display("FAIL wd_recover: found=%0b error=%0b, expected 1 0", found, error);
        end
    endtask

    task automatic test_stray_inputs();
        push_keys(0);
        pulse_go();
        cyc();                      // INIT_WAIT
        swap_done = 1'b1;
        cyc();
        swap_done = 1'b0;
        n_cmp++;
        if (swap_start !== 1'b0 || dec_start !== 1'b0 || mem_sel !== 2'd0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL stray_swap: swap_start=%0b dec_start=%0b mem_sel=%0d busy=%0b, expected 0 0 0 1", swap_start, dec_start, mem_sel, busy);
        end
        dec_done = 1'b1; dec_pass = 1'b1;
        cyc();
        dec_done = 1'b0; dec_pass = 1'b0;
        n_cmp++;
        if (found !== 1'b0 || dec_start !== 1'b0 || mem_sel !== 2'd0) begin
            n_err++;
            $display("FAIL stray_dec: found=%0b dec_start=%0b mem_sel=%0d, expected 0 0 0", found, dec_start, mem_sel);
        end
        pulse_go();
        n_cmp++;
        if (init_start !== 1'b0 || secret_key !== '0 || mem_sel !== 2'd0) begin
            n_err++;
            $display("FAIL stray_go: init_start=%0b key=%0h mem_sel=%0d, expected 0 0 0", init_start, secret_key, mem_sel);
        end
        init_done = 1'b1;
        cyc();
        init_done = 1'b0;
        n_cmp++;
        if (swap_start !== 1'b1 || mem_sel !== 2'd1) begin
            n_err++;
            $display("FAIL stray_resume: swap_start=%0b mem_sel=%0d, expected 1 1", swap_start, mem_sel);
        end
        cyc();                      // SWAP_WAIT: wrong-machine dones
        init_done = 1'b1; dec_done = 1'b1; dec_pass = 1'b1;
        cyc();
        init_done = 1'b0; dec_done = 1'b0; dec_pass = 1'b0;
        n_cmp++;
        if (mem_sel !== 2'd1 || dec_start !== 1'b0 || found !== 1'b0) begin
            n_err++;
            $display("FAIL stray_swap_wait: mem_sel=%0d dec_start=%0b found=%0b, expected 1 0 0", mem_sel, dec_start, found);
        end
        swap_done = 1'b1;
        cyc();
        swap_done = 1'b0;
        run_phase(2, 2, 1'b1);
        n_cmp++;
        if (found !== 1'b1 || secret_key !== '0) begin
            n_err++;
            $display("FAIL stray_complete: found=%0b key=%0h, expected 1 0", found, secret_key);
        end
    endtask

    task automatic test_reset_mid();
        push_keys(0);
        pulse_go();
        serve_partial();
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (init_start !== 1'b0 || swap_start !== 1'b0 || dec_start !== 1'b0 || mem_sel !== 2'd3 ||
            secret_key !== '0 || busy !== 1'b0 || found !== 1'b0 || not_found !== 1'b0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: starts=%0b%0b%0b mem_sel=%0d key=%0h flags=%0b%0b%0b%0b", init_start, swap_start, dec_start, mem_sel, secret_key, busy, found, not_found, error);
        end
        exp_q.delete();             // the interrupted key never reaches dec_start
        cyc();
        reset_n = 1'b1;
        repeat (3) cyc();
        n_cmp++;
        if (busy !== 1'b0 || init_start !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_resume: busy=%0b init_start=%0b, expected 0 0", busy, init_start);
        end
        push_keys(0);
        pulse_go();
        serve(0, 2, 2, 2);
    endtask

    // Runs key 0 to a fail and key 1 into SWAP_WAIT.
    task automatic serve_partial();
        run_phase(0, 2, 1'b0);
        run_phase(1, 2, 1'b0);
        run_phase(2, 2, 1'b0);
        exp_q.push_back(KW'(1));
        cyc();
        n_cmp++;
        if (init_start !== 1'b1 || secret_key !== KW'(1)) begin
            n_err++;
            $display("FAIL mid_key1: init_start=%0b key=%0h, expected 1 1", init_start, secret_key);
        end
        run_phase(0, 2, 1'b0);
        cyc();                      // now in SWAP_WAIT for key 1
        n_cmp++;
        if (mem_sel !== 2'd1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_swap_wait: mem_sel=%0d busy=%0b, expected 1 1", mem_sel, busy);
        end
    endtask

    initial begin
        test_reset();
        test_found_first();
        test_found_later();
        test_exhaustion();
        test_watchdog();
        test_stray_inputs();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d keys left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
